// File: rtl/ysyx_040729_exe_div_ctrl_if.sv
// EXE-side request/response and divider-core handshake bundle for ysyx_040729_exe_div_ctrl.
// slave = the controller's view; master = the EXE stage plus divider core.
interface ysyx_040729_exe_div_ctrl_if;
  localparam int unsigned XLEN = 64;

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic            is_w;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  logic            core_div_valid;
  logic            core_div_ready;
  logic            core_divw;
  logic            core_flush;
  logic [XLEN-1:0] core_dividend;
  logic [XLEN-1:0] core_divisor;
  logic            core_out_valid;
  logic [XLEN-1:0] core_quotient;
  logic [XLEN-1:0] core_remainder;

  modport slave (
    input  in_valid, op, is_w, src1, src2, flush, out_ready,
           core_div_ready, core_out_valid, core_quotient, core_remainder,
    output in_ready, out_valid, result,
           core_div_valid, core_divw, core_flush, core_dividend, core_divisor
  );

  modport master (
    output in_valid, op, is_w, src1, src2, flush, out_ready,
           core_div_ready, core_out_valid, core_quotient, core_remainder,
    input  in_ready, out_valid, result,
           core_div_valid, core_divw, core_flush, core_dividend, core_divisor
  );
endinterface

// File: rtl/ysyx_040729_exe_div_ctrl.sv
// RV64M divide/remainder sign handling and sequencing around an unsigned iterative core.
// Optional YSYX_040729_DIV_SHORTCUT_EN resolves divide-by-zero/overflow at accept without the core.
module ysyx_040729_exe_div_ctrl (
  input logic                       clock,
  input logic                       reset,
  ysyx_040729_exe_div_ctrl_if.slave bus
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned HALF = 32;
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state;
  logic            is_rem;
  logic            is_w_q;
  logic            neg_q;
  logic            neg_r;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] dividend_q;

  function automatic logic [XLEN-1:0] fix_w(input logic w, input logic [XLEN-1:0] v);
    return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  // Divide-by-zero takes precedence; otherwise the overflow rule applies
  function automatic logic [XLEN-1:0] special_res(input logic rem, input logic w,
                                                  input logic dz, input logic [XLEN-1:0] dvd);
    if (dz) return rem ? fix_w(w, dvd) : {XLEN{1'b1}};
    return rem ? {XLEN{1'b0}} : fix_w(w, dvd);
  endfunction

  // Accept-time operand extension, magnitudes and special-case detection
  logic            sgn_c, sa_c, sb_c, dz_c, ovf_c;
  logic [XLEN-1:0] a_ext_c, b_ext_c, abs_a_c, abs_b_c;

  always_comb begin
    sgn_c   = ~bus.op[0];
    a_ext_c = bus.src1;
    b_ext_c = bus.src2;
    if (bus.is_w) begin
      a_ext_c = {{HALF{sgn_c & bus.src1[HALF-1]}}, bus.src1[HALF-1:0]};
      b_ext_c = {{HALF{sgn_c & bus.src2[HALF-1]}}, bus.src2[HALF-1:0]};
    end
    sa_c    = sgn_c & a_ext_c[XLEN-1];
    sb_c    = sgn_c & b_ext_c[XLEN-1];
    abs_a_c = sa_c ? XLEN'({XLEN{1'b0}} - a_ext_c) : a_ext_c;
    abs_b_c = sb_c ? XLEN'({XLEN{1'b0}} - b_ext_c) : b_ext_c;
    dz_c    = (b_ext_c == {XLEN{1'b0}});
    ovf_c   = sgn_c & (a_ext_c == (bus.is_w ? MIN_W : MIN_D)) & (b_ext_c == {XLEN{1'b1}});
  end

  // Completion-time sign fixup and override
  logic [XLEN-1:0] raw_c, signed_c, fin_c;

  always_comb begin
    raw_c = is_rem ? bus.core_remainder : bus.core_quotient;
    if (is_w_q) raw_c = {{HALF{1'b0}}, raw_c[HALF-1:0]};
    signed_c = (is_rem ? neg_r : neg_q) ? XLEN'({XLEN{1'b0}} - raw_c) : raw_c;
    fin_c    = (div_zero | ovf) ? special_res(is_rem, is_w_q, div_zero, dividend_q)
                                : fix_w(is_w_q, signed_c);
  end

  // Issue pulse lands in the first ready ISSUE cycle; a flush suppresses it
  assign bus.core_div_valid = (state == ISSUE) & bus.core_div_ready & ~bus.flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      bus.in_ready      <= 1'b1;
      bus.out_valid     <= 1'b0;
      bus.result        <= {XLEN{1'b0}};
      bus.core_flush    <= 1'b0;
      bus.core_divw     <= 1'b0;
      bus.core_dividend <= {XLEN{1'b0}};
      bus.core_divisor  <= {XLEN{1'b0}};
      is_rem            <= 1'b0;
      is_w_q            <= 1'b0;
      neg_q             <= 1'b0;
      neg_r             <= 1'b0;
      div_zero          <= 1'b0;
      ovf               <= 1'b0;
      dividend_q        <= {XLEN{1'b0}};
    end else begin
      bus.core_flush <= 1'b0;
      if (bus.flush) begin
        bus.core_flush <= (state == ISSUE) || (state == WAIT);
        state          <= IDLE;
        bus.in_ready   <= 1'b1;
        bus.out_valid  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (bus.in_valid) begin
            is_rem            <= bus.op[1];
            is_w_q            <= bus.is_w;
            neg_q             <= sa_c ^ sb_c;
            neg_r             <= sa_c;
            div_zero          <= dz_c;
            ovf               <= ovf_c;
            dividend_q        <= a_ext_c;
            bus.core_divw     <= bus.is_w;
            bus.core_dividend <= bus.is_w ? {abs_a_c[HALF-1:0], {HALF{1'b0}}} : abs_a_c;
            bus.core_divisor  <= bus.is_w ? {abs_b_c[HALF-1:0], {HALF{1'b0}}} : abs_b_c;
            bus.in_ready      <= 1'b0;
            state             <= ISSUE;
`ifdef YSYX_040729_DIV_SHORTCUT_EN
            if (dz_c | ovf_c) begin
              bus.result    <= special_res(bus.op[1], bus.is_w, dz_c, a_ext_c);
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end
`endif
          end
          ISSUE: if (bus.core_div_ready) state <= WAIT;
          WAIT: if (bus.core_out_valid) begin
            bus.result    <= fin_c;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
          DONE: if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/ysyx_040729_exe_div_ctrl.md
# ysyx_040729_exe_div_ctrl

Sign-handling and sequencing controller that sits in the EXE stage between the ALU op decode and the iterative unsigned divider core. It accepts RV64M DIV/DIVU/REM/REMU and their W forms, converts the operands to magnitudes, and drives the core through its valid/ready/flush handshake. When the core finishes, the block applies the sign fixup, the divide-by-zero rule and the signed-overflow rule. It holds the 64-bit result until EXE accepts it.

## Interface
- XLEN, 64, datapath width; the only supported value is 64.
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE.
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- is_w  in  1  32-bit W variant.
- src1, src2  in  XLEN  dividend, divisor.
- flush  in  1  pipeline kill; aborts any operation in flight.
- out_valid  out  1  result valid (registered).
- out_ready  in  1  EXE accepts the result.
- result  out  XLEN  final quotient or remainder; W forms are sign-extended from bit 31.
- core_div_valid  out  1  one-cycle issue pulse to the core.
- core_div_ready  in  1  the core is idle.
- core_divw  out  1  selects the core's 32-iteration mode.
- core_flush  out  1  one-cycle abort pulse to the core.
- core_dividend, core_divisor  out  XLEN  unsigned operands for the core.
- core_out_valid  in  1  one-cycle completion pulse from the core.
- core_quotient, core_remainder  in  XLEN  unsigned results from the core.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: on in_valid & ~flush, latch the op, operands and flags, then go to ISSUE.
  - signed = ~op[0].
  - For W forms, the operands are taken from bits [31:0] and sign- or zero-extended according to signed.
- Magnitudes: |a| and |b| are the two's-complement negation when signed and the sign bit is set; otherwise the value is passed unchanged.
  - neg_q = sa ^ sb.
  - neg_r = sa.
  - Here sa and sb are the operand sign bits when signed, else 0.
- Core operand packing:
  - 64-bit: core_dividend = |a|, core_divisor = |b|, core_divw = 0.
  - W: core_dividend = {|a|[31:0], 32'b0}, core_divisor = {|b|[31:0], 32'b0}, core_divw = 1.
  - The core operand outputs are driven from registers and stay stable from ISSUE through WAIT.
- ISSUE: assert core_div_valid for exactly one cycle, in the first cycle that core_div_ready is high, then go to WAIT. If core_div_ready is low, stay in ISSUE.
- WAIT: on core_out_valid, capture the core results and go to DONE.
  - The result is taken from core_quotient[W?31:0 : 63:0] or core_remainder in the same bit range.
  - The result is negated by neg_q (quotient) or neg_r (remainder).
  - For W forms, the result is then sign-extended from bit 31.
- Special cases override the computed result:
  - Divisor zero (in the width of the op): quotient = all ones; remainder = the dividend, sign-extended for W forms.
  - Signed overflow, i.e. most-negative / -1: quotient = the dividend; remainder = 0.
- DONE: out_valid = 1 with result stable. On out_ready, go to IDLE.
- flush in any state: go to IDLE on the next edge and drop out_valid. If the state is ISSUE or WAIT, also pulse core_flush for one cycle. A core_out_valid arriving after a flush is ignored.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, result = 0, core_div_valid = 0, core_flush = 0, core_divw = 0, core operands = 0.
- Latency, with the accept at edge T and the core ready:
  - core_div_valid is high in cycle T+1.
  - core_out_valid arrives at T+1+N, where N is the core latency (64 for 64-bit ops, 32 for W ops).
  - out_valid is high from T+2+N.
- Throughput is one operation in flight at a time. in_ready is low from T+1 until DONE is left.
- out_valid and out_ready both high: the result is consumed. in_ready rises the next cycle and a new op can be accepted in that cycle.
- flush and in_valid in the same cycle: flush wins and the op is not accepted.
- flush and out_ready in the same cycle in DONE: the result is dropped. The state becomes IDLE either way.
- reset asserted in mid-operation: all outputs return to their reset values asynchronously. No core_flush is generated; the core shares the same reset.

## Configuration
- YSYX_040729_DIV_SHORTCUT_EN defined:
  - Divide-by-zero and signed overflow are detected in IDLE at accept time.
  - The core is never issued for these cases. The state goes directly to DONE, with out_valid high at T+1.
- YSYX_040729_DIV_SHORTCUT_EN undefined:
  - These cases go through ISSUE/WAIT with the full core latency.
  - The override is applied when core_out_valid arrives.
  - Final results are identical in both builds.

## Test plan
- DIV src1 = -7, src2 = 2 -> result 0xFFFFFFFFFFFFFFFD. REM with the same operands -> 0xFFFFFFFFFFFFFFFF. out_valid at T+66.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. Hold out_ready low for 5 cycles -> result stable and in_ready stays 0.
- DIV 5/0 -> 0xFFFFFFFFFFFFFFFF; REM 5/0 -> 5. With the macro, out_valid at T+1 and core_div_valid never asserted. Without the macro, out_valid at T+66.
- DIV 0x8000000000000000 / -1 -> 0x8000000000000000, REM -> 0. DIVW 0x80000000 / 0xFFFFFFFF -> 0xFFFFFFFF80000000.
- DIVW src1 = 0x00000000FFFFFFF9, src2 = 2 -> 0xFFFFFFFFFFFFFFFD, with core_divw = 1 and out_valid at T+34. REMUW 0xFFFFFFFF / 16 -> 0xF.
- Flush 10 cycles into WAIT -> core_flush pulses once and out_valid never rises for that op. A following DIVU 9/3 accepted the next cycle -> 3.
